// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared constants for the FIFO write-port arbiter.
// Holds the FSM state encoding, default geometry and a constant clog2.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_MAXBURST  = 4;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } arb_state_e;

  // Ceiling log2 for elaboration-time widths; clog2(1) is 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between producers, the arbiter and the FIFO write side.
// With FIFO_WR_ARB_TAG_EN defined, fifo_data carries {owner, payload}.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DATAWIDTH = DEF_DATAWIDTH
);
  localparam int IDW = clog2(NREQ);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FDW = DATAWIDTH + IDW;
`else
  localparam int FDW = DATAWIDTH;
`endif

  logic [NREQ-1:0]                req;
  logic [NREQ-1:0][DATAWIDTH-1:0] data_in;
  logic [NREQ-1:0]                ready;
  logic                           fifo_full;
  logic                           fifo_wenable;
  logic [FDW-1:0]                 fifo_data;
  logic [IDW-1:0]                 owner;
  logic                           busy;

  // Arbiter side: drives the FIFO write port and per-requester accepts.
  modport master (
    input  req, data_in, fifo_full,
    output ready, fifo_wenable, fifo_data, owner, busy
  );

  // Producer/FIFO side.
  modport slave (
    output req, data_in, fifo_full,
    input  ready, fifo_wenable, fifo_data, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set req bit scanning from ptr+1 upward, modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic [IDW:0]    start;
  logic [IDW:0]    off;
  logic [IDW:0]    sum;
  logic [NREQ-1:0] rot;

  // Rotate so rot[0] is the requester right after ptr; a start of NREQ
  // (ptr == NREQ-1) selects the upper copy, i.e. requester 0 first.
  always_comb begin
    start = {1'b0, ptr} + (IDW+1)'(1);
    rot   = NREQ'({req, req} >> start);
  end

  // Lowest set bit of the rotated view, mapped back with an explicit wrap
  // so non-power-of-2 NREQ works.
  always_comb begin
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = (IDW+1)'(j);
    end
    sum = start + off;
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    winner = sum[IDW-1:0];
    any    = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of the async FIFO's single write port.
// A grant lasts up to MAXBURST accepted beats, ends early when the owner
// drops req, and stalls (no timeout) while fifo_full is high. One IDLE
// bubble separates grants. Optional macro FIFO_WR_ARB_TAG_EN prefixes the
// written word with the owner index.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int MAXBURST  = DEF_MAXBURST
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int IDW = clog2(NREQ);
  localparam int BCW = clog2(MAXBURST + 1);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FDW = DATAWIDTH + IDW;
`else
  localparam int FDW = DATAWIDTH;
`endif

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [IDW-1:0]  winner;
  logic            any;
  logic            busy;
  logic [NREQ-1:0] ready;
  logic            wen;
  logic            owner_req;
  logic            last_beat;
  logic [DATAWIDTH-1:0] payload;
  logic [FDW-1:0]  fdata;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign busy      = (state_q == S_GRANT);
  assign owner_req = bus.req[owner_q];
  assign last_beat = (beat_cnt_q == BCW'(MAXBURST - 1));

  // Per-requester accept: only the owner, only while it asserts req and
  // the FIFO has room, so at most one bit is ever high.
  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign ready[i] = busy && (owner_q == IDW'(i)) && bus.req[i] && !bus.fifo_full;
  end

  assign wen     = |ready;
  assign payload = bus.data_in[owner_q];

  // Write word is forced to zero when no beat transfers.
  always_comb begin
    fdata = '0;
`ifdef FIFO_WR_ARB_TAG_EN
    if (wen) fdata = {owner_q, payload};
`else
    if (wen) fdata = payload;
`endif
  end

  assign bus.ready        = ready;
  assign bus.fifo_wenable = wen;
  assign bus.fifo_data    = fdata;
  assign bus.owner        = owner_q;
  assign bus.busy         = busy;

  // Next-state: pick in IDLE; in GRANT a req drop or the last accepted
  // beat releases the port and moves the round-robin pointer to the owner.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          owner_d    = winner;
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!owner_req) begin
          state_d  = S_IDLE;
          rr_ptr_d = owner_q;
        end else if (wen) begin
          if (last_beat) begin
            state_d  = S_IDLE;
            rr_ptr_d = owner_q;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; rr_ptr resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= IDW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers stream base[i]+n, expected writes are
// queued as each scenario is set up and popped whenever fifo_wenable is seen.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FDW = DW + 2;
`else
  localparam int FDW = DW;
`endif

  typedef struct packed {
    logic [1:0]     own;
    logic [FDW-1:0] word;
  } exp_t;

  logic clk;
  logic rst_n;
  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATAWIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .MAXBURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_we  = 0;
  exp_t sb[$];
  logic [7:0] base [NREQ];
  int         sent [NREQ];

  logic           s_we, s_busy;
  logic [3:0]     s_ready;
  logic [1:0]     s_owner;
  logic [FDW-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [7:0] p);
    exp_t e;
    e.own = 2'(id);
`ifdef FIFO_WR_ARB_TAG_EN
    e.word = {2'(id), p};
`else
    e.word = p;
`endif
    return e;
  endfunction

  task automatic push_run(input int id, input int first, input int n);
    for (int k = 0; k < n; k++) sb.push_back(mk(id, base[id] + 8'(first + k)));
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.data_in[i] = base[i] + 8'(sent[i]);
  endtask

  // One clock: sample and score at negedge, advance producers after posedge.
  task automatic cycle();
    logic [3:0] acc;
    exp_t e;
    @(negedge clk);
    s_we = bus.fifo_wenable; s_ready = bus.ready; s_owner = bus.owner;
    s_busy = bus.busy; s_data = bus.fifo_data;
    chk("we_is_or_ready", 32'(s_we), 32'(|s_ready));
    chk("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
    if (bus.fifo_full) chk("no_we_when_full", 32'(s_we), 32'd0);
    if (!s_we) chk("data_zero_idle", 32'(s_data), 32'd0);
    if (s_we) begin
      if (sb.size() == 0) chk("sb_unexpected_write", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("sb_owner", 32'(s_owner), 32'(e.own));
        chk("sb_data", 32'(s_data), 32'(e.word));
      end
    end
    acc = s_ready & bus.req;
    n_we += int'(s_we);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) sent[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.req = '0; bus.fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin sent[i] = 0; base[i] = 8'(i * 16); end
    drive_data();
    cycle(); cycle();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_owner", 32'(s_owner), 32'd0);
    chk("rst_data", 32'(s_data), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] pat;
    rst_n = 1'b0; bus.req = '0; bus.fifo_full = 1'b0; bus.data_in = '0;

    // Basic: single requester, grant latency, burst of 4, bubble, regrant.
    do_reset();
    base[0] = 8'hA0; drive_data();
    bus.req = 4'b0001;
    push_run(0, 0, 5);
    pat = 7'b1011110;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("basic_we_pattern", 32'(s_we), 32'(pat[k]));
    end
    bus.req = '0;
    cycle();
    chk("basic_drop_no_we", 32'(s_we), 32'd0);
    cycle();
    chk("basic_sb_left", 32'(sb.size()), 32'd0);

    // Fairness: all requesting, owners 0,1,2,3,0 with 4 beats each.
    do_reset();
    bus.req = 4'b1111;
    for (int r = 0; r < 4; r++) push_run(r, 0, 4);
    push_run(0, 4, 4);
    n_we = 0;
    for (int k = 0; k < 25; k++) cycle();
    chk("fair_duty", 32'(n_we), 32'd20);
    bus.req = '0;
    cycle();
    chk("fair_sb_left", 32'(sb.size()), 32'd0);

    // Back-pressure: full for 3 cycles at beat 2 of owner 1.
    do_reset();
    base[1] = 8'h40; drive_data();
    bus.req = 4'b0010;
    push_run(1, 0, 4);
    cycle(); cycle(); cycle();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_stall_we", 32'(s_we), 32'd0);
      chk("bp_stall_ready1", 32'(s_ready[1]), 32'd0);
      chk("bp_stall_busy", 32'(s_busy), 32'd1);
    end
    bus.fifo_full = 1'b0;
    cycle(); chk("bp_beat2", 32'(s_we), 32'd1);
    cycle(); chk("bp_beat3", 32'(s_we), 32'd1);
    cycle(); chk("bp_burst_end", 32'(s_busy), 32'd0);
    bus.req = '0;
    cycle();
    chk("bp_sb_left", 32'(sb.size()), 32'd0);

    // Request drop: owner 2 drops after beat 1, then 3, 0, and 2 again.
    do_reset();
    base[0] = 8'h50; base[2] = 8'h60; base[3] = 8'h70; drive_data();
    bus.req = 4'b1100;
    push_run(2, 0, 2);
    cycle(); cycle(); cycle();
    bus.req = 4'b1001;
    cycle();
    chk("drop_no_we", 32'(s_we), 32'd0);
    chk("drop_still_busy", 32'(s_busy), 32'd1);
    bus.req = 4'b1101;
    push_run(3, 0, 4); push_run(0, 0, 4); push_run(2, 2, 4);
    cycle();
    chk("drop_idle", 32'(s_busy), 32'd0);
    for (int k = 6; k < 20; k++) begin
      cycle();
      if (k == 6)  chk("drop_next_owner3", 32'(s_owner), 32'd3);
      if (k == 11) chk("drop_then_owner0", 32'(s_owner), 32'd0);
      if (k == 16) chk("drop_then_owner2", 32'(s_owner), 32'd2);
    end
    bus.req = '0;
    cycle(); cycle();
    chk("drop_sb_left", 32'(sb.size()), 32'd0);

    // Mid-burst reset on owner 1, then requester 0 wins first.
    do_reset();
    base[1] = 8'h90; base[0] = 8'h50; drive_data();
    bus.req = 4'b0010;
    push_run(1, 0, 3);
    cycle(); cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("mrst_busy", 32'(s_busy), 32'd0);
    chk("mrst_we", 32'(s_we), 32'd0);
    chk("mrst_ready", 32'(s_ready), 32'd0);
    chk("mrst_owner", 32'(s_owner), 32'd0);
    chk("mrst_data", 32'(s_data), 32'd0);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    push_run(0, 0, 1);
    cycle();
    chk("mrst_idle", 32'(s_busy), 32'd0);
    cycle();
    chk("mrst_first_owner", 32'(s_owner), 32'd0);
    chk("mrst_first_we", 32'(s_we), 32'd1);
    bus.req = '0;
    cycle();
    chk("mrst_sb_left", 32'(sb.size()), 32'd0);

    // Requester 3 word: tagged {2'b11, 8'h5C} or plain 8'h5C.
    do_reset();
    base[3] = 8'h5C; drive_data();
    bus.req = 4'b1000;
    push_run(3, 0, 1);
    cycle(); cycle();
`ifdef FIFO_WR_ARB_TAG_EN
    chk("tag_word", 32'(s_data), 32'h35C);
`else
    chk("tag_word", 32'(s_data), 32'h5C);
`endif
    bus.req = '0;
    cycle();
    chk("tag_sb_left", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter in the write clock domain of the async FIFO. It shares the FIFO's single write port (data, write enable, full) among NREQ requesters. A granted requester streams bursts of up to MAXBURST beats under back-pressure from the FIFO full flag. It sits between the write-side producers and the FIFO's write-domain inputs.

## Interface
- NREQ, 4: number of requesters, 2..16
- DATAWIDTH, 8: data width per requester; must match the FIFO DATAWIDTH (see Configuration)
- MAXBURST, 4: maximum beats per grant, at least 1
- IDW (localparam): clog2(NREQ)
- clk  in  1  write-domain clock; connect to the FIFO's wclk
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- req  in  NREQ  per-requester request/valid; held while data is presented
- data_in  in  NREQ*DATAWIDTH  requester i data in bits [i*DATAWIDTH +: DATAWIDTH]
- ready  out  NREQ  per-requester accept; a beat transfers when req[i] && ready[i]
- fifo_full  in  1  FIFO full flag
- fifo_wenable  out  1  FIFO write enable
- fifo_data  out  DATAWIDTH (+IDW with tag)  FIFO write data
- owner  out  IDW  index of the current grant holder
- busy  out  1  high while in GRANT

## Operation
- FSM states:
  - IDLE: if |req, select a winner with the round-robin pick (below). Set owner <= winner, beat_cnt <= 0, next state GRANT. Otherwise stay in IDLE.
  - GRANT, exit on request drop: !req[owner] goes to IDLE and rr_ptr <= owner. No transfer occurs that cycle.
  - GRANT, burst end: an accepted beat with beat_cnt == MAXBURST-1 goes to IDLE and rr_ptr <= owner.
  - GRANT, other accepted beat: beat_cnt <= beat_cnt + 1, stay in GRANT.
  - GRANT, fifo_full with req[owner] high: stall. beat_cnt holds, state holds, no timeout.
- Round-robin pick: the first set req bit scanning from rr_ptr+1 upward, modulo NREQ.
- Output logic (combinational):
  - ready[i] = busy && owner==i && req[i] && !fifo_full.
  - fifo_wenable = |ready.
  - fifo_data = data_in slice of owner when fifo_wenable is high, otherwise 0.
- Widths: beat_cnt is clog2(MAXBURST+1) bits; rr_ptr and owner are IDW bits. Wrap of rr_ptr+1 from NREQ-1 to 0 is explicit, and NREQ is not required to be a power of 2.
- Never writes when fifo_full is high. At most one ready bit is high per cycle.
- A requester that drops req mid-burst loses its grant. Its next request re-arbitrates.

## Timing
- Reset values: state IDLE, owner 0, beat_cnt 0, rr_ptr NREQ-1 (req[0] wins first). All outputs are 0.
- Reset asserted mid-burst: the next edge returns to IDLE. Outputs go low from that edge; no partial beat is written.
- Grant latency: 1 cycle. req rises at edge N, and the first transfer is possible in cycle N+1.
- Transfer is zero-latency once granted. fifo_full going high blocks the write in that same cycle.
- One idle bubble cycle between consecutive grants. Sustained throughput is MAXBURST/(MAXBURST+1) beats per cycle.
- Simultaneous events:
  - Last beat with full low and other requests pending: IDLE, then the next requester by round-robin.
  - Request drop together with fifo_full: IDLE, with no transfer.

## Configuration
- FIFO_WR_ARB_TAG_EN defined:
  - fifo_data is DATAWIDTH+IDW bits: {owner, payload}.
  - The FIFO is instantiated with DATAWIDTH+IDW so the read side recovers the source requester.
  - When fifo_wenable is low the whole word is 0.
- Not defined: fifo_data is DATAWIDTH bits of payload only.

## Structure
- Package fifo_arb_pkg holds:
  - state encoding localparams ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - the clog2 constant function;
  - the default NREQ, DATAWIDTH and MAXBURST values.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ] and ptr[IDW].
  - Outputs: winner[IDW] and any.
  - Instantiated once in IDLE decode.
- FSM, counter and output muxing stay in fifo_wr_arbiter.

## Test plan
- Basic: after reset, req=4'b0001 held with data 8'hA0..A3 and fifo_full=0. Required: grant after 1 cycle, 4 writes A0..A3 on consecutive cycles, one IDLE cycle, then grant again.
- Fairness: req=4'b1111 held, MAXBURST=4. Required: owner sequence 0,1,2,3,0, 4 beats each, and fifo_wenable duty is 4 of every 5 cycles.
- Back-pressure: fifo_full=1 for 3 cycles at beat 2 of owner 1. Required:
  - no fifo_wenable during the stall and ready[1]=0;
  - beat_cnt holds;
  - beats 2..3 complete after full deasserts.
- Request drop: owner 2 drops req after beat 1 with req[3] pending. Required: IDLE next cycle, then owner 3; owner 2 is not revisited before 3 and 0.
- Mid-burst reset: rst_n=0 at beat 2. Required: all outputs 0 from the next edge; after release, req[0] wins first.
- Tag: with FIFO_WR_ARB_TAG_EN, a requester 3 write of 8'h5C gives fifo_data={2'b11, 8'h5C}.
